// File: rtl/three_way_lamp_ctrl_pkg.sv
// Shared encodings, lamp state type and counter-width helper for the three-way lamp controller.
package three_way_pkg;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_X1   = 2'd1;
  localparam logic [1:0] SRC_X2   = 2'd2;
  localparam logic [1:0] SRC_X3   = 2'd3;

  typedef enum logic {
    LAMP_OFF = 1'b0,
    LAMP_ON  = 1'b1
  } lamp_state_t;

  // Never returns 0 so a counter always has at least one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/three_way_lamp_ctrl_debounce.sv
// One switch channel: 2-flop synchroniser, saturating debounce counter, accepted level
// and a one-cycle request pulse on the cycle a new level is accepted.
module switch_debounce
  import three_way_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic req_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    req_d   = 1'b0;
    cnt_d   = '0;
    // Any cycle of agreement clears the count, dropping short glitches.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        req_d   = 1'b1;
      end else if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/three_way_lamp_ctrl.sv
// Three-way lamp controller: debounces three raw switches and toggles the lamp on the
// parity of accepted toggles. Optional idle auto-off enabled by macro AUTO_OFF_EN.
module three_way_lamp_ctrl
  import three_way_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       x1,
  input  logic       x2,
  input  logic       x3,
  output logic       f,
  output logic       toggle_evt,
  output logic [1:0] src
);

  if (DEBOUNCE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("three_way_lamp_ctrl: DEBOUNCE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [2:0] raw_w;
  logic [2:0] req_w;

  assign raw_w = {x3, x2, x1};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw (
      .clk  (clk),
      .rst_n(rst_n),
      .raw_i(raw_w[gi]),
      .req_o(req_w[gi])
    );
  end

  lamp_state_t state_q, state_d;
  logic        toggle_q, toggle_d;
  logic [1:0]  src_q, src_d;
  logic        any_req;
  logic        parity;
  logic [1:0]  lowest_src;

  assign any_req = |req_w;
  assign parity  = ^req_w;

  always_comb begin
    if (req_w[0])      lowest_src = SRC_X1;
    else if (req_w[1]) lowest_src = SRC_X2;
    else               lowest_src = SRC_X3;
  end

`ifdef AUTO_OFF_EN
  localparam int IW = cnt_width(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d  = state_q;
    toggle_d = 1'b0;
    src_d    = src_q;
`ifdef AUTO_OFF_EN
    idle_d   = idle_q;
`endif
    // Cancelling requests still record their source even though the lamp holds.
    if (any_req) begin
      src_d = lowest_src;
      if (parity) begin
        state_d  = (state_q == LAMP_ON) ? LAMP_OFF : LAMP_ON;
        toggle_d = 1'b1;
      end
    end
`ifdef AUTO_OFF_EN
    // A request in the timeout cycle reloads the timer and suppresses the timeout.
    if (any_req) begin
      idle_d = '0;
    end else if (state_q == LAMP_ON) begin
      if (idle_q == IDLE_LAST) begin
        state_d = LAMP_OFF;
        src_d   = SRC_NONE;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LAMP_OFF;
      toggle_q <= 1'b0;
      src_q    <= SRC_NONE;
    end else begin
      state_q  <= state_d;
      toggle_q <= toggle_d;
      src_q    <= src_d;
    end
  end

`ifdef AUTO_OFF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign f          = (state_q == LAMP_ON);
  assign toggle_evt = toggle_q;
  assign src        = src_q;

endmodule
